// File: rtl/ifu_fetch.sv
// Instruction fetch: one imem read at a time, result held for the decoder; latency handshake->inst_valid = resp cycle + 1.
// Backpressure: HOLD keeps inst/inst_pc stable and issues no new request until inst_ready; redirect overrides everything.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  logic [31:0] ibuf;
  logic [63:0] ibuf_pc;
  logic        ibuf_ld;
  logic [63:0] redir_tgt;

  assign redir_tgt = redirect_pc & ~64'd3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      ibuf    <= '0;
      ibuf_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
      if (ibuf_ld) begin
        ibuf    <= imem_resp_data;
        ibuf_pc <= pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    ibuf_ld   = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (redirect_valid) begin
          pc_nxt = redir_tgt;
          // The old address was accepted this cycle, so its response must be swallowed.
          if (imem_req_ready) begin
            state_nxt = WAIT;
            drop_nxt  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redir_tgt;
          if (imem_resp_valid) begin
            state_nxt = REQ;
            drop_nxt  = 1'b0;
          end else begin
            drop_nxt = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = REQ;
          end else begin
            ibuf_ld   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redir_tgt;
          state_nxt = REQ;
        end else if (inst_ready) begin
          pc_nxt    = pc + 64'd4;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address is gated so nothing but a live request ever shows a nonzero value.
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = imem_req_valid ? pc : 64'd0;
  assign inst_valid     = (state == HOLD);
  assign inst           = ibuf;
  assign inst_pc        = ibuf_pc;

endmodule
